inst_mem_sync: RTL and testbench

//  Parametrised synchronous instruction memory for the MIPS fetch stage; successor to the combinational ROM.

---
 rtl/inst_mem_pkg.sv | 22 ++
 rtl/inst_mem_array.sv | 38 +++
 rtl/inst_mem_sync.sv | 108 ++++++++++
 tb/tb_inst_mem_sync.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared constants and address helpers for the synchronous instruction memory.
// Address math is done at a fixed wide width so one helper serves any ADDR_W up to 64.
package inst_mem_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam logic [WORD_W-1:0] INST_NOP = 32'h0;
    localparam int unsigned MAX_ADDR_W = 64;

    typedef logic [MAX_ADDR_W-1:0] addr_t;

    // Returns {borrow, word index}: ADDR_W-bit unsigned (addr - base) >> 2, borrow set when addr < base.
    function automatic logic [MAX_ADDR_W:0] word_index(input addr_t       addr,
                                                       input addr_t       base,
                                                       input int unsigned addr_w);
        addr_t mask;
        addr_t diff;
        mask = (addr_w >= MAX_ADDR_W) ? '1 : ((addr_t'(1) << addr_w) - addr_t'(1));
        diff = (addr - base) & mask;
        return {addr < base, diff >> 2};
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// 1R1W word RAM with registered, read-first output; storage is never reset so it maps to block RAM.
// Contents start as NOP; images are loaded through the write port.
module inst_mem_array import inst_mem_pkg::*; #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = "",
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rd_data_q;

    initial begin
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            mem[i] = INST_NOP;
        end
    end

    // Non-blocking read of mem gives read-first behaviour on a same-word collision.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory for the fetch stage: valid/ready request and response,
// flush on redirect, loader write port, and alignment/range error flags.
module inst_mem_sync import inst_mem_pkg::*; #(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       ADDR_W      = 32,
    parameter string             INIT_FILE   = "",
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_err_al,
    output logic              resp_err_rg,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [MAX_ADDR_W:0] req_wi;
    logic [MAX_ADDR_W:0] wr_wi;
    logic                req_misal;
    logic                req_oor;
    logic                wr_ok;
    logic                accept;
    logic [WORD_W-1:0]   rd_data;

    logic              valid_q,   valid_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              err_al_q,  err_al_d;
    logic              err_rg_q,  err_rg_d;
    logic              data_ok_q, data_ok_d;

    assign req_wi    = word_index(addr_t'(req_addr), addr_t'(BASE_ADDR), ADDR_W);
    assign wr_wi     = word_index(addr_t'(wr_addr), addr_t'(BASE_ADDR), ADDR_W);
    assign req_misal = (req_addr[1:0] != 2'b00);
    assign req_oor   = req_wi[MAX_ADDR_W] |
                       (req_wi[MAX_ADDR_W-1:0] >= addr_t'(DEPTH_WORDS));
    assign wr_ok     = wr_en & (wr_addr[1:0] == 2'b00) & ~wr_wi[MAX_ADDR_W] &
                       (wr_wi[MAX_ADDR_W-1:0] < addr_t'(DEPTH_WORDS));

    assign req_ready = ce & (~valid_q | resp_ready | flush);
    assign accept    = req_valid & req_ready;

    inst_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk       (clk),
        .rd_en_i   (accept),
        .rd_idx_i  (req_wi[IDX_W-1:0]),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_ok),
        .wr_idx_i  (wr_wi[IDX_W-1:0]),
        .wr_data_i (wr_data)
    );

    always_comb begin
        valid_d   = valid_q;
        addr_d    = addr_q;
        err_al_d  = err_al_q;
        err_rg_d  = err_rg_q;
        data_ok_d = data_ok_q;
        if (accept) begin
            valid_d   = 1'b1;
            addr_d    = req_addr;
            err_al_d  = req_misal;
            err_rg_d  = ~req_misal & req_oor;
            data_ok_d = ~req_misal & ~req_oor;
        end else if (resp_ready | flush) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            addr_q    <= '0;
            err_al_q  <= 1'b0;
            err_rg_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            err_al_q  <= err_al_d;
            err_rg_q  <= err_rg_d;
            data_ok_q <= data_ok_d;
        end
    end

    // RAM output is not reset, so gate it until a clean fetch has landed.
    assign resp_data   = data_ok_q ? rd_data : INST_NOP;
    assign resp_valid  = valid_q;
    assign resp_addr   = addr_q;
    assign resp_err_al = err_al_q;
    assign resp_err_rg = err_rg_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural memory/handshake model.
module tb_inst_mem_sync;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b0, wr_en = 1'b0;
    logic [31:0] req_addr = '0, wr_addr = '0, wr_data = '0;
    logic        req_ready, resp_valid, resp_err_al, resp_err_rg;
    logic [31:0] resp_data, resp_addr;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    inst_mem_sync #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (32),
        .INIT_FILE   (""),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_addr   (resp_addr),
        .resp_err_al (resp_err_al),
        .resp_err_rg (resp_err_rg),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: word store plus the one held response.
    logic [31:0] m_mem [DEPTH];
    logic        m_valid = 1'b0, m_al = 1'b0, m_rg = 1'b0;
    logic [31:0] m_data = '0, m_addr = '0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
    end

    function automatic bit in_range(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off / 4 < longint'(DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    // Returns {err_al, err_rg, data} for a fetch of a against the current model contents.
    function automatic logic [33:0] model_fetch(input logic [31:0] a);
        if (a[1:0] != 2'b00) return {2'b10, 32'h0};
        if (!in_range(a))    return {2'b01, 32'h0};
        return {2'b00, m_mem[widx(a)]};
    endfunction

    always @(posedge clk) begin
        if (wr_en && wr_addr[1:0] == 2'b00 && in_range(wr_addr))
            m_mem[widx(wr_addr)] <= wr_data;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_al <= 1'b0; m_rg <= 1'b0; m_data <= '0; m_addr <= '0;
        end else if (req_valid && ce && (!m_valid || resp_ready || flush)) begin
            m_valid <= 1'b1;
            m_addr  <= req_addr;
            {m_al, m_rg, m_data} <= model_fetch(req_addr);
        end else if (resp_ready || flush) begin
            m_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(ce & (~m_valid | resp_ready | flush)));
            check("resp_valid", 32'(resp_valid), 32'(m_valid));
            check("resp_data", resp_data, m_data);
            check("resp_addr", resp_addr, m_addr);
            check("err_al", 32'(resp_err_al), 32'(m_al));
            check("err_rg", 32'(resp_err_rg), 32'(m_rg));
        end
    end

    task automatic drive(input logic c, input logic f, input logic rv, input logic [31:0] ra,
                         input logic rr, input logic we, input logic [31:0] wa,
                         input logic [31:0] wd);
        ce = c; flush = f; req_valid = rv; req_addr = ra; resp_ready = rr;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7)  return {22'h0, 8'($urandom_range(0, 63)), 2'b00};
        if (sel == 7) return {24'h0, 8'($urandom)} | 32'h1 | 32'($urandom_range(0, 1) << 1);
        if (sel == 8) return 32'h1000 + {$urandom_range(0, 255), 2'b00};
        return $urandom;
    endfunction

    initial begin
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset resp_valid", 32'(resp_valid), 32'h0);
        check("reset resp_data", resp_data, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Boot-load an image: word i = A500_0000 | i.
        for (int i = 0; i < 32; i++)
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i));
        idle();

        // Back-to-back fetches.
        drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("b2b word0", resp_data, 32'hA500_0000);
        drive(1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
        check("b2b word1", resp_data, 32'hA500_0001);
        drive(1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
        check("b2b word2", resp_data, 32'hA500_0002);
        check("b2b valid", 32'(resp_valid), 32'h1);
        idle();

        // Stall holds the response and blocks new requests.
        drive(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
            check("stall req_ready", 32'(req_ready), 32'h0);
            check("stall data", resp_data, 32'hA500_0004);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 32'h0);
        check("after stall", resp_data, 32'hA500_0005);

        // Error flags.
        drive(1'b1, 1'b0, 1'b1, 32'h6, 1'b1, 1'b0, 32'h0, 32'h0);
        check("misaligned al", 32'(resp_err_al), 32'h1);
        check("misaligned data", resp_data, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0, 32'h0);
        check("range rg", 32'(resp_err_rg), 32'h1);
        check("range al", 32'(resp_err_al), 32'h0);

        // Read-first collision, then new word, then ignored misaligned write.
        drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        check("collision old", resp_data, 32'hA500_0008);
        drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h22, 32'h1234_5678);
        check("write new", resp_data, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 32'h0);
        check("misaligned write ignored", resp_data, 32'hDEAD_BEEF);
        idle();

        // Flush with a new request while stalled.
        drive(1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        check("flush new data", resp_data, 32'hA500_0010);
        check("flush new addr", resp_addr, 32'h40);

        // Asynchronous reset while a response is held.
        rst = 1'b1;
        #1;
        check("async rst valid", 32'(resp_valid), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("post-reset word0", resp_data, 32'hA500_0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 5) == 0), rand_addr(), $urandom);
        end
        idle();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
